serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract engine. Sequences a single 1-bit full-adder cell
//   (ports z, cout, a, b, cin) over WIDTH cycles, LSB first. A registered

---
 rtl/serial_add_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell is stepped LSB first over WIDTH
// cycles, with a registered carry loop, between valid/ready operand and result ports.

module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic z,
  output logic cout
);
  assign z    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             z;
  logic             cout;

  serial_add_fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .z    (z),
    .cout (cout)
  );

  // Sum bits enter at the MSB so the LSB-first result lands in place after WIDTH steps.
  assign sum_next = {z, sum_sh[WIDTH-1:1]};
  assign out_sum  = sum_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1: invert B and seed the carry with 1.
            a_sh     <= in_a;
            b_sh     <= in_sub ? ~in_b : in_b;
            carry    <= in_sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_cout  <= cout;
            out_ovf   <= carry ^ cout;
            out_zero  <= (sum_next == '0);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and model-checked random bench for serial_add_ctrl at WIDTH=8 and WIDTH=32.

module tb_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv8 = 1'b0, iv32 = 1'b0, sub = 1'b0, flush = 1'b0, ordy = 1'b0;
  logic        sel32 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        rdy8, vld8, co8, of8, z8;
  logic [7:0]  s8;
  logic        rdy32, vld32, co32, of32, z32;
  logic [31:0] s32;
  int          n_vec = 0, n_err = 0, cyc = 0, prev_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .in_sub(sub),
    .in_a(a[7:0]), .in_b(b[7:0]), .flush(flush), .out_valid(vld8), .out_ready(ordy),
    .out_sum(s8), .out_cout(co8), .out_ovf(of8), .out_zero(z8)
  );

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .in_sub(sub),
    .in_a(a), .in_b(b), .flush(flush), .out_valid(vld32), .out_ready(ordy),
    .out_sum(s32), .out_cout(co32), .out_ovf(of32), .out_zero(z32)
  );

  function automatic logic f_rdy();         return sel32 ? rdy32 : rdy8;      endfunction
  function automatic logic f_vld();         return sel32 ? vld32 : vld8;      endfunction
  function automatic logic f_co();          return sel32 ? co32 : co8;        endfunction
  function automatic logic f_of();          return sel32 ? of32 : of8;        endfunction
  function automatic logic f_z();           return sel32 ? z32 : z8;          endfunction
  function automatic logic [31:0] f_sum();  return sel32 ? s32 : {24'd0, s8}; endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; signed overflow from operand/result signs.
  task automatic model(input bit w32, input bit s, input logic [31:0] aa, input logic [31:0] bb,
                       output logic [31:0] es, output bit ec, output bit eo, output bit ez);
    logic [32:0] full;
    logic [31:0] m;
    int          w;
    bit          sa, sb, ss;
    w    = w32 ? 32 : 8;
    m    = w32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
    full = s ? ({1'b0, aa & m} - {1'b0, bb & m}) : ({1'b0, aa & m} + {1'b0, bb & m});
    es   = full[31:0] & m;
    ec   = s ? ((aa & m) >= (bb & m)) : full[w];
    sa   = aa[w-1];
    sb   = bb[w-1];
    ss   = es[w-1];
    eo   = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    ez   = (es == 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input bit w32, input bit s, input logic [31:0] aa, input logic [31:0] bb,
                          output int acc);
    int t;
    sel32 = w32; sub = s; a = aa; b = bb;
    if (w32) iv32 = 1'b1; else iv8 = 1'b1;
    t = 0;
    while (!f_rdy() && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    iv8 = 1'b0; iv32 = 1'b0;
  endtask

  task automatic run_op(input bit w32, input bit s, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] es, input bit ec, input bit eo, input bit ez,
                        input int hold, input bit pulse, input bit chk_per, input string tag);
    int acc, lat, w;
    w = w32 ? 32 : 8;
    start_op(w32, s, aa, bb, acc);
    if (chk_per) chk({tag, "_period"}, 32'((acc - prev_acc) >= w + 2), 32'd1);
    prev_acc = acc;
    ordy = (hold == 0);
    lat = 0;
    while (!f_vld() && lat < w + 4) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(w));
    chk({tag, "_sum"}, f_sum(), es);
    chk({tag, "_flags"}, {29'd0, f_co(), f_of(), f_z()}, {29'd0, ec, eo, ez});
    for (int i = 0; i < hold; i++) begin
      if (pulse && (i % 2 == 0)) begin
        a = 32'h55; if (w32) iv32 = 1'b1; else iv8 = 1'b1;
      end else begin
        iv8 = 1'b0; iv32 = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_hold"}, {27'd0, f_vld(), f_rdy(), f_co(), f_of(), f_z()},
          {27'd0, 1'b1, 1'b0, ec, eo, ez});
      chk({tag, "_hold_sum"}, f_sum(), es);
    end
    iv8 = 1'b0; iv32 = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({tag, "_idle"}, {30'd0, f_vld(), f_rdy()}, 32'b01);
  endtask

  task automatic no_valid_for(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (f_vld() || !f_rdy()) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, es;
    bit          rs, ec, eo, ez;
    int          acc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out", {f_sum()[7:0], 4'd0, f_vld(), f_co(), f_of(), f_z()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(f_rdy()), 32'd1);

    // Directed add/sub vectors at WIDTH=8
    run_op(0, 0, 32'h7F, 32'h01, 32'h80, 0, 1, 0, 0, 0, 0, "add7f01");
    run_op(0, 1, 32'h05, 32'h05, 32'h00, 1, 0, 1, 0, 0, 0, "sub0505");
    run_op(0, 1, 32'h00, 32'h01, 32'hFF, 0, 0, 0, 0, 0, 0, "sub0001");
    run_op(0, 1, 32'h80, 32'h01, 32'h7F, 1, 1, 0, 0, 0, 0, "sub8001");

    // Result held under back-pressure with ignored in_valid pulses
    run_op(0, 0, 32'hFF, 32'h01, 32'h00, 1, 0, 1, 5, 1, 0, "addff01");
    no_valid_for(2, "hold_no_accept");

    // Asynchronous reset in the middle of RUN
    start_op(0, 0, 32'hAA, 32'h11, acc);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(f_vld()), 32'd0);
    @(negedge clk);
    chk("midrst_sum", f_sum(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(f_rdy()), 32'd1);
    no_valid_for(12, "midrst_discard");
    run_op(0, 0, 32'h12, 32'h34, 32'h46, 0, 0, 0, 0, 0, 0, "add1234");

    // flush during RUN, then flush together with in_valid in IDLE
    start_op(0, 0, 32'h01, 32'h02, acc);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {30'd0, f_vld(), f_rdy()}, 32'b01);
    no_valid_for(11, "flush_discard");
    flush = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    flush = 1'b0; iv8 = 1'b0;
    chk("flush_reject", 32'(f_rdy()), 32'd1);
    no_valid_for(11, "flush_no_accept");
    run_op(0, 1, 32'h40, 32'h41, 32'hFF, 0, 0, 0, 0, 0, 0, "sub4041");

    // Back-to-back random ops against the reference model
    for (int k = 0; k < 100; k++) begin
      ra = $urandom & 32'hFF; rb = $urandom & 32'hFF; rs = 1'($urandom_range(0, 1));
      model(0, rs, ra, rb, es, ec, eo, ez);
      run_op(0, rs, ra, rb, es, ec, eo, ez, $urandom_range(0, 2), 0, k > 0, "rnd8");
    end
    for (int k = 0; k < 100; k++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (k == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h1; rs = 1'b0; end
      model(1, rs, ra, rb, es, ec, eo, ez);
      run_op(1, rs, ra, rb, es, ec, eo, ez, $urandom_range(0, 2), 0, k > 0, "rnd32");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
